// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  // Also compiled into the firmware headers as the bus-error read pattern.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam int ERR_COUNT_W = 8;

  function automatic logic pick_master(input logic v0, input logic v1,
                                       input logic last_served, input logic round_robin);
    if (v0 && v1) return round_robin ? ~last_served : M_CPU;
    if (v1) return M_AUX;
    return M_CPU;
  endfunction

endpackage

// File: rtl/bus_timeout_wdt.sv
// rtl/bus_timeout_wdt.sv - bus access watchdog with error address capture and saturating count
module bus_timeout_wdt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic                   ack,
  input  logic [31:0]            addr,
  output logic                   expire,
  output logic [31:0]            err_addr,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_COUNT_W-1:0] CNT_MAX = '1;

  logic [15:0]            cnt_q, cnt_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;

  // An ack in the final cycle beats the timeout, so expire is masked by ack.
  always_comb begin
    expire      = run && !ack && (cnt_q == LAST);
    cnt_d       = (run && !ack && !expire) ? cnt_q + 16'd1 : 16'd0;
    err_addr_d  = expire ? addr : err_addr_q;
    err_count_d = err_count_q;
    if (expire && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for the PicoRV32 native memory bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   m0_valid,
  input  logic [31:0]            m0_addr,
  input  logic [31:0]            m0_wdata,
  input  logic [3:0]             m0_wstrb,
  output logic                   m0_ready,
  output logic [31:0]            m0_rdata,
  input  logic                   m1_valid,
  input  logic [31:0]            m1_addr,
  input  logic [31:0]            m1_wdata,
  input  logic [3:0]             m1_wstrb,
  output logic                   m1_ready,
  output logic [31:0]            m1_rdata,
  output logic                   s_valid,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  input  logic                   s_ready,
  input  logic [31:0]            s_rdata,
  output logic                   bus_err,
  output logic [31:0]            err_addr,
  output logic [ERR_COUNT_W-1:0] err_count,
  output logic                   owner
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic        busy, run, done, expire;
  logic        own_valid;
  logic [31:0] own_addr, own_wdata, fin_rdata;
  logic [3:0]  own_wstrb;

  assign busy      = (state_q == ST_BUSY);
  assign own_valid = (owner_q == M_AUX) ? m1_valid : m0_valid;
  assign own_addr  = (owner_q == M_AUX) ? m1_addr  : m0_addr;
  assign own_wdata = (owner_q == M_AUX) ? m1_wdata : m0_wdata;
  assign own_wstrb = (owner_q == M_AUX) ? m1_wstrb : m0_wstrb;

  // A withdrawn request stops the watchdog, so it can neither complete nor time out.
  assign run  = busy && own_valid;
  assign done = run && s_ready;

  bus_timeout_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clock     (clock),
    .resetn    (resetn),
    .run       (run),
    .ack       (s_ready),
    .addr      (own_addr),
    .expire    (expire),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always_comb begin
    s_valid   = run && !expire;
    s_addr    = busy ? own_addr  : 32'd0;
    s_wdata   = busy ? own_wdata : 32'd0;
    s_wstrb   = busy ? own_wstrb : 4'd0;
    bus_err   = expire;
    fin_rdata = expire ? ERR_RDATA : s_rdata;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = 32'd0;
    m1_rdata  = 32'd0;
    if (done || expire) begin
      if (owner_q == M_AUX) begin
        m1_ready = 1'b1;
        m1_rdata = fin_rdata;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = fin_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          owner_d = pick_master(m0_valid, m1_valid, last_q, ROUND_ROBIN);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_valid) begin
          state_d = ST_IDLE;
        end else if (done || expire) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to the aux master so the CPU wins the first contest.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= M_CPU;
      last_q  <= M_AUX;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready, m1_ready, s_valid, bus_err, owner;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, err_addr;
  logic [3:0]  s_wstrb;
  logic [7:0]  err_count;

  logic        f_m0_ready, f_m1_ready, f_s_valid, f_bus_err, f_owner;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata, f_err_addr;
  logic [3:0]  f_s_wstrb;
  logic [7:0]  f_err_count;

  int errors = 0;
  int checks = 0;

  bit          sel_fp;
  bit          fixed_en;
  logic [31:0] fixed_rdata;
  int          slave_lat;
  bit          lat_rand_en;
  int          rnd_lat = 2;
  int          lat_cnt = 0;
  logic        sel_sv;
  logic [31:0] sel_addr;
  int          eff_lat;

  req_t exp_q0[$];
  req_t exp_q1[$];

  always #5 clock = ~clock;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign sel_sv   = sel_fp ? f_s_valid : s_valid;
  assign sel_addr = sel_fp ? f_s_addr : s_addr;
  assign s_rdata  = fixed_en ? fixed_rdata : rd_fn(sel_addr);
  assign eff_lat  = lat_rand_en ? rnd_lat : slave_lat;

  // Slave model: registered ready, asserted after eff_lat cycles of s_valid; 0 = never.
  always @(posedge clock) begin
    if (!resetn || !sel_sv || s_ready) begin
      lat_cnt <= 0;
      s_ready <= 1'b0;
    end else begin
      lat_cnt <= lat_cnt + 1;
      s_ready <= (eff_lat != 0) && (lat_cnt + 1 == eff_lat);
    end
    if (s_ready) rnd_lat <= $urandom_range(1, 4);
  end

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(1'b1)) dut (
    .clock(clock), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count), .owner(owner)
  );

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(1'b0)) dut_fp (
    .clock(clock), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
    .s_valid(f_s_valid), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(f_bus_err), .err_addr(f_err_addr), .err_count(f_err_count), .owner(f_owner)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    sel_fp = 1'b0; fixed_en = 1'b0; fixed_rdata = '0;
    slave_lat = 0; lat_rand_en = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_wdata = '0; m1_wdata = '0;
    m0_wstrb = 4'hF; m1_wstrb = 4'hF;
    sel_fp = 1'b0; fixed_en = 1'b0; fixed_rdata = '0; slave_lat = 0; lat_rand_en = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({s_valid, m0_ready, m1_ready, bus_err, owner} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {s_valid, m0_ready, m1_ready, bus_err, owner});
    end
    checks++;
    if ({s_addr, s_wdata, s_wstrb} !== 68'd0) begin
      errors++; $display("FAIL reset_slave_bus got=%h exp=0", {s_addr, s_wdata, s_wstrb});
    end
    checks++;
    if ({m0_rdata, m1_rdata, err_addr, err_count} !== 104'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {m0_rdata, m1_rdata, err_addr, err_count});
    end
  endtask

  task automatic test_single();
    do_reset();
    slave_lat = 1; fixed_en = 1'b1; fixed_rdata = 32'h1234_5678;
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
    @(negedge clock);
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL single_arb_cycle s_valid got=%b exp=0", s_valid); end
    next_cycle(); @(negedge clock);
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'h10 || m0_ready !== 1'b0) begin
      errors++; $display("FAIL single_busy got v=%b a=%h r=%b exp v=1 a=00000010 r=0", s_valid, s_addr, m0_ready);
    end
    next_cycle(); @(negedge clock);
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL single_done got r0=%b d=%h r1=%b exp r0=1 d=12345678 r1=0", m0_ready, m0_rdata, m1_ready);
    end
    next_cycle(); m0_valid = 1'b0; @(negedge clock);
    checks++;
    if (m0_ready !== 1'b0 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL single_after got r0=%b v=%b r1=%b exp 0 0 0", m0_ready, s_valid, m1_ready);
    end
  endtask

  task automatic test_contention(input bit fp);
    int got[$];
    int last_rdy;
    bit prev_rdy;
    logic sv, r0, r1;
    logic [31:0] d;
    do_reset();
    sel_fp = fp; slave_lat = 1;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_valid = 1'b1; m1_valid = 1'b1;
    last_rdy = -1; prev_rdy = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      sv = fp ? f_s_valid : s_valid;
      r0 = fp ? f_m0_ready : m0_ready;
      r1 = fp ? f_m1_ready : m1_ready;
      if (prev_rdy) begin
        checks++;
        if (sv !== 1'b0) begin errors++; $display("FAIL contend_bubble fp=%0d cyc=%0d s_valid got=%b exp=0", fp, c, sv); end
      end
      if (r0 === 1'b1 || r1 === 1'b1) begin
        d = r1 ? (fp ? f_m1_rdata : m1_rdata) : (fp ? f_m0_rdata : m0_rdata);
        checks++;
        if (r0 === r1 || d !== rd_fn(r1 ? m1_addr : m0_addr)) begin
          errors++; $display("FAIL contend_done fp=%0d r0=%b r1=%b data=%h exp=%h", fp, r0, r1, d, rd_fn(r1 ? m1_addr : m0_addr));
        end
        if (last_rdy >= 0) begin
          checks++;
          if (c - last_rdy != 3) begin errors++; $display("FAIL contend_spacing fp=%0d got=%0d exp=3", fp, c - last_rdy); end
        end
        got.push_back(r1 ? 1 : 0);
        last_rdy = c;
      end
      prev_rdy = r0 | r1;
      next_cycle();
    end
    checks++;
    if (got.size() < 4) begin
      errors++; $display("FAIL contend_count fp=%0d got=%0d exp>=4", fp, got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] != (fp ? 0 : i % 2)) begin
          errors++; $display("FAIL contend_order fp=%0d idx=%0d got=m%0d exp=m%0d", fp, i, got[i], fp ? 0 : i % 2);
        end
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int total;
    int exp_cnt;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
    @(negedge clock);
    for (int b = 1; b <= 8; b++) begin
      next_cycle(); @(negedge clock);
      checks++;
      if (b < 8 && {m0_ready, bus_err, s_valid} !== 3'b001) begin
        errors++; $display("FAIL timeout_wait cyc=%0d got=%b exp=001", b, {m0_ready, bus_err, s_valid});
      end else if (b == 8 && ({m0_ready, bus_err, s_valid, m1_ready} !== 4'b1100 || m0_rdata !== 32'hDEAD_BEEF)) begin
        errors++; $display("FAIL timeout_fire got=%b d=%h exp=1100 d=deadbeef", {m0_ready, bus_err, s_valid, m1_ready}, m0_rdata);
      end
    end
    next_cycle(); m0_valid = 1'b0; @(negedge clock);
    checks++;
    if (err_addr !== 32'h0300_0000 || err_count !== 8'd1 || m0_ready !== 1'b0) begin
      errors++; $display("FAIL timeout_regs got a=%h c=%0d r=%b exp a=03000000 c=1 r=0", err_addr, err_count, m0_ready);
    end
    total = 1;
    m0_addr = 32'h0300_0040; m0_valid = 1'b1;
    for (int c = 0; c < 3000 && total < 260; c++) begin
      @(negedge clock);
      if (bus_err === 1'b1) total++;
      next_cycle();
    end
    m0_valid = 1'b0;
    checks++;
    if (total != 260) begin errors++; $display("FAIL saturate_pulses got=%0d exp=260", total); end
    next_cycle(); @(negedge clock);
    exp_cnt = (total > 255) ? 255 : total;
    checks++;
    if (err_count !== 8'(exp_cnt) || err_addr !== 32'h0300_0040) begin
      errors++; $display("FAIL saturate_count got c=%0d a=%h exp c=%0d a=03000040", err_count, err_addr, exp_cnt);
    end
  endtask

  task automatic test_race();
    do_reset();
    slave_lat = 7;
    m0_valid = 1'b1; m0_addr = 32'h0300_0004; m0_wstrb = 4'h0;
    @(negedge clock);
    for (int b = 1; b <= 8; b++) begin
      next_cycle(); @(negedge clock);
      checks++;
      if (bus_err !== 1'b0 || m0_ready !== (b == 8)) begin
        errors++; $display("FAIL race_cycle cyc=%0d err=%b rdy=%b exp err=0 rdy=%0d", b, bus_err, m0_ready, b == 8);
      end
    end
    checks++;
    if (m0_rdata !== rd_fn(32'h0300_0004)) begin
      errors++; $display("FAIL race_data got=%h exp=%h", m0_rdata, rd_fn(32'h0300_0004));
    end
    next_cycle(); m0_valid = 1'b0; @(negedge clock);
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL race_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_withdraw_reset();
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0400_0000; m1_wstrb = 4'h0;
    next_cycle(); @(negedge clock);
    checks++;
    if (s_valid !== 1'b1 || owner !== 1'b1) begin
      errors++; $display("FAIL withdraw_grant got v=%b own=%b exp v=1 own=1", s_valid, owner);
    end
    next_cycle(); m1_valid = 1'b0; @(negedge clock);
    checks++;
    if ({s_valid, m1_ready, bus_err} !== 3'b000) begin
      errors++; $display("FAIL withdraw_drop got=%b exp=000", {s_valid, m1_ready, bus_err});
    end
    next_cycle(); @(negedge clock);
    checks++;
    if ({s_valid, m1_ready, bus_err} !== 3'b000) begin
      errors++; $display("FAIL withdraw_idle got=%b exp=000", {s_valid, m1_ready, bus_err});
    end
    next_cycle(); m1_valid = 1'b1;
    next_cycle(); @(negedge clock);
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_busy s_valid got=%b exp=1", s_valid); end
    @(posedge clock); #2 resetn = 1'b0; #1;
    checks++;
    if ({s_valid, m1_ready, m0_ready, owner, bus_err} !== 5'b0 || s_addr !== 32'd0 || s_wstrb !== 4'd0) begin
      errors++; $display("FAIL rst_async got=%b a=%h exp=00000 a=0", {s_valid, m1_ready, m0_ready, owner, bus_err}, s_addr);
    end
    m0_valid = 1'b1; m0_addr = 32'h0000_0050;
    next_cycle(); resetn = 1'b1;
    next_cycle(); @(negedge clock);
    checks++;
    if (owner !== 1'b0 || s_addr !== 32'h0000_0050 || s_valid !== 1'b1) begin
      errors++; $display("FAIL rst_first_grant got own=%b a=%h v=%b exp own=0 a=00000050 v=1", owner, s_addr, s_valid);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_write_strobe();
    int sv_cycles;
    bool_loop: begin
    end
    do_reset();
    slave_lat = 3;
    m1_valid = 1'b1; m1_addr = 32'h0200_0000; m1_wdata = 32'h0000_00AB; m1_wstrb = 4'b0001;
    sv_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (s_valid === 1'b1) begin
        sv_cycles++;
        checks++;
        if (s_wstrb !== 4'b0001 || s_wdata !== 32'h0000_00AB || s_addr !== 32'h0200_0000) begin
          errors++; $display("FAIL wstrb_pass got s=%b d=%h a=%h exp s=0001 d=000000ab a=02000000", s_wstrb, s_wdata, s_addr);
        end
      end
      if (m1_ready === 1'b1) break;
      next_cycle();
    end
    checks++;
    if (m1_ready !== 1'b1 || sv_cycles != 4) begin
      errors++; $display("FAIL wstrb_done got r=%b cycles=%0d exp r=1 cycles=4", m1_ready, sv_cycles);
    end
    next_cycle(); @(negedge clock);
    checks++;
    if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL wstrb_bubble got v=%b r=%b exp 0 0", s_valid, m1_ready);
    end
    m1_valid = 1'b0;
  endtask

  task automatic drive_master(input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      req_t r;
      bit seen;
      repeat ($urandom_range(0, 2)) next_cycle();
      r.addr  = $urandom & 32'hFFFF_FFFC;
      r.wdata = $urandom;
      r.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (m) begin
        m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb; m1_valid = 1'b1; exp_q1.push_back(r);
      end else begin
        m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb; m0_valid = 1'b1; exp_q0.push_back(r);
      end
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clock);
        seen = m ? (m1_ready === 1'b1) : (m0_ready === 1'b1);
        if (!seen) next_cycle();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL random_wait m%0d txn=%0d no ready within 100 cycles", m, i); end
      next_cycle();
      if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    localparam int N = 30;
    bit   drivers_done;
    bit   must_valid;
    logic must;
    logic w;
    int   n_done;
    req_t e;
    logic [31:0] rd;
    do_reset();
    lat_rand_en = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    drivers_done = 1'b0; must_valid = 1'b0; must = 1'b0; n_done = 0;
    fork
      begin
        fork
          drive_master(1'b0, N);
          drive_master(1'b1, N);
        join
        drivers_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !drivers_done; c++) begin
          @(negedge clock);
          if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            w = m1_ready;
            checks++;
            if ((m0_ready === 1'b1 && m1_ready === 1'b1) || bus_err !== 1'b0 ||
                (w ? exp_q1.size() : exp_q0.size()) == 0) begin
              errors++; $display("FAIL random_done_bad r0=%b r1=%b err=%b", m0_ready, m1_ready, bus_err);
            end else begin
              e  = w ? exp_q1.pop_front() : exp_q0.pop_front();
              rd = w ? m1_rdata : m0_rdata;
              checks++;
              if (rd !== rd_fn(e.addr) || s_addr !== e.addr || s_wdata !== e.wdata || s_wstrb !== e.wstrb) begin
                errors++; $display("FAIL random_txn m%0d got a=%h d=%h s=%h rd=%h exp a=%h d=%h s=%h rd=%h",
                                   w, s_addr, s_wdata, s_wstrb, rd, e.addr, e.wdata, e.wstrb, rd_fn(e.addr));
              end
              if (must_valid) begin
                checks++;
                if (w !== must) begin errors++; $display("FAIL random_fair got=m%0d exp=m%0d", w, must); end
              end
              must_valid = w ? (m0_valid === 1'b1) : (m1_valid === 1'b1);
              must = ~w;
              n_done++;
            end
          end
        end
      end
    join
    checks++;
    if (n_done != 2 * N || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++; $display("FAIL random_total got=%0d left=%0d/%0d exp=%0d", n_done, exp_q0.size(), exp_q1.size(), 2 * N);
    end
    lat_rand_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention(1'b0);
    test_contention(1'b1);
    test_timeout();
    test_race();
    test_withdraw_reset();
    test_write_strobe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single PicoRV32 native memory bus (the bus feeding the ROM/RAM/LED/7-seg/RGB/button/UART slave decode) between two masters.
- m0 is the CPU. m1 is a secondary master (DMA / UART boot loader).
- A bus-timeout watchdog completes any access that no slave acknowledges, so unmapped addresses no longer hang the CPU.
- Sits between the masters and the existing slave decode / ready-rdata mux.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without s_ready before a forced error completion; legal range 2..65535.
- ROUND_ROBIN, 1: 1 = alternate priority on contention; 0 = fixed priority, m0 wins.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports:
- clock, input, 1: system clock (clock_main domain).
- resetn, input, 1: asynchronous active-low reset.
- m0_valid / m1_valid, input, 1: master request.
- m0_addr / m1_addr, input, 32: byte address.
- m0_wdata / m1_wdata, input, 32: write data.
- m0_wstrb / m1_wstrb, input, 4: byte strobes; 0 = read.
- m0_ready / m1_ready, output, 1: completion pulse to master.
- m0_rdata / m1_rdata, output, 32: read data to master.
- s_valid, output, 1: request to slave decode.
- s_addr, output, 32: address to slave decode.
- s_wdata, output, 32: write data to slave decode.
- s_wstrb, output, 4: byte strobes to slave decode.
- s_ready, input, 1: OR of slave readies.
- s_rdata, input, 32: muxed slave read data.
- bus_err, output, 1: one-cycle pulse on timeout completion.
- err_addr, output, 32: address of the last timed-out access.
- err_count, output, 8: saturating count of timeouts.
- owner, output, 1: current/last granted master (debug).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; clock and reset ports are named `clock` and `resetn`.
- Reset values:
  - state = IDLE; owner = 0; last_served = 1, so m0 wins the first round-robin contest.
  - s_valid, s_addr, s_wdata, s_wstrb = 0; m*_ready = 0; m*_rdata = 0.
  - bus_err = 0, err_addr = 0, err_count = 0, timeout counter = 0.
- States: IDLE, BUSY.
- IDLE:
  - s_valid = 0.
  - If only one m*_valid is high, grant that master.
  - If both are high: with ROUND_ROBIN=1, grant the master != last_served; with ROUND_ROBIN=0, grant m0.
  - On a grant: register owner, go to BUSY next cycle, clear the counter.
  - If neither is valid, stay in IDLE.
- BUSY, slave side: s_valid/s_addr/s_wdata/s_wstrb are combinational pass-through of the owner's signals.
- BUSY, completion:
  - When s_ready = 1: owner_ready = 1 in the same cycle and owner_rdata = s_rdata (combinational).
  - Next cycle: IDLE, last_served <= owner.
- BUSY, timeout:
  - The counter increments each cycle while s_ready = 0.
  - When the counter == TIMEOUT_CYCLES-1 and s_ready = 0: s_valid = 0, owner_ready = 1, owner_rdata = ERR_RDATA.
  - Same cycle: bus_err = 1, err_addr <= owner addr, err_count <= err_count+1, saturating at 255.
  - Next cycle: IDLE.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
- BUSY, owner withdraws: if the owner's valid drops (illegal for PicoRV32, legal for m1), go to IDLE next cycle with no ready and no error.
- Non-owner: ready = 0 and rdata = 0 at all times; its request waits in place.
- Latency: one arbitration cycle plus slave latency. A back-to-back request from the same master sees a one-cycle IDLE bubble. This guarantees s_valid is low for at least one cycle between transactions, so registered slave readies (valid && !ready) never double-fire.
- Starvation: with ROUND_ROBIN=1, a continuously requesting master waits at most one transaction of the other master.
- Reset mid-transaction: all outputs drop immediately (async); the pending access is discarded.
- Writes: the wstrb pattern is passed unchanged; no width conversion.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_BUSY);
  - master index constants (M_CPU = 0, M_AUX = 1);
  - the default ERR_RDATA constant, shared with firmware headers.
- One natural sub-module: bus_timeout_wdt. It holds the counter, compare, and the err_addr/err_count registers, with inputs run, ack, addr and outputs expire, err_addr, err_count.

Test Plan:
- Single access: m0 read of 0x0000_0010; slave answers ready 1 cycle after s_valid with 0x1234_5678 → s_valid rises 1 cycle after m0_valid, m0_ready pulses once, m0_rdata = 0x1234_5678, m1_ready stays 0.
- Contention, ROUND_ROBIN=1: m0 and m1 both hold valid from reset → grants go m0, m1, m0, m1, with one IDLE cycle between each. Repeat with ROUND_ROBIN=0 → m0 is always granted while valid.
- Timeout, TIMEOUT_CYCLES=8: m0 reads 0x0300_0000 and s_ready is never asserted → m0_ready plus bus_err pulse in the 8th BUSY cycle, m0_rdata = 0xDEAD_BEEF, err_addr = 0x0300_0000, err_count = 1. With the count preset near 255, repeated timeouts hold it at 255.
- Race: s_ready asserted in exactly the timeout cycle → normal completion with slave data, bus_err = 0, err_count unchanged.
- Withdraw and reset: m1 drops valid in BUSY → IDLE next cycle, no ready. Then resetn pulsed low mid-BUSY → all outputs 0 asynchronously, and the first post-reset contention grants m0.
- Write strobes: m1 writes 0x0000_00AB with wstrb = 4'b0001 to 0x0200_0000 → s_wstrb = 4'b0001 and s_wdata = 0x0000_00AB for the whole BUSY window, and s_valid is low the cycle after ready.
